osd_num_overlay: RTL and testbench

- Video-path consumer of the OSD register-file outputs (enable, soft reset, coordinate, colour, number, resolution).
- Counts pixels of an incoming RGB stream and renders `osd_num` as three hex digits in 7-segment style at the programmed coordinate, in the programmed colour.
- All other pixels pass through unchanged, with fixed pipeline latency and no backpressure.

---
 rtl/osd_num_overlay.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_osd_num_overlay.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_num_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : osd_num_overlay
//  Description : Renders a 12-bit value as three 7-segment hex digits on top
//                of an RGB pixel stream at a programmable position and colour.
//                Non-overlay pixels pass through with a fixed 2-cycle latency.
//  Ports       : aclk/aresetn       clock, async active-low reset
//                osd_ip_en          overlay enable (shadowed at frame start)
//                osd_ip_rstn        synchronous active-low soft reset pulse
//                coordinate         {y0[31:16], x0[15:0]} of digit box
//                rgb_color          overlay colour {R,G,B}
//                osd_num            value shown, [11:8] leftmost digit
//                h_res/v_res        active pixels per line / lines per frame
//                frame_start_i      one-cycle frame start pulse
//                data_valid_i,r/g/b_i   input pixel stream
//                data_valid_o,r/g/b_o   output pixel stream
//  Revision    : 1.0  initial release
// ============================================================================
module osd_num_overlay #(
  parameter int G_DATA_WIDTH = 8,
  parameter int SCALE_LOG2   = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    osd_ip_en,
  input  logic                    osd_ip_rstn,
  input  logic [31:0]             coordinate,
  input  logic [23:0]             rgb_color,
  input  logic [11:0]             osd_num,
  input  logic [15:0]             h_res,
  input  logic [15:0]             v_res,
  input  logic                    frame_start_i,
  input  logic                    data_valid_i,
  input  logic [G_DATA_WIDTH-1:0] r_i,
  input  logic [G_DATA_WIDTH-1:0] g_i,
  input  logic [G_DATA_WIDTH-1:0] b_i,
  output logic                    data_valid_o,
  output logic [G_DATA_WIDTH-1:0] r_o,
  output logic [G_DATA_WIDTH-1:0] g_o,
  output logic [G_DATA_WIDTH-1:0] b_o
);

  localparam logic [15:0] BOX_W = 16'(24 << SCALE_LOG2);
  localparam logic [15:0] BOX_H = 16'(8 << SCALE_LOG2);

  // --------------------------------------------------------------------------
  // Shadow registers. The _d values double as the "effective" settings for
  // the current pixel, so a pixel coincident with frame_start_i already sees
  // the newly latched configuration.
  // --------------------------------------------------------------------------
  logic        en_q,    en_d;
  logic [15:0] x0_q,    x0_d;
  logic [15:0] y0_q,    y0_d;
  logic [23:0] color_q, color_d;
  logic [11:0] num_q,   num_d;
  logic [15:0] hres_q,  hres_d;
  logic [15:0] vres_q,  vres_d;

  always_comb begin
    en_d    = en_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    color_d = color_q;
    num_d   = num_q;
    hres_d  = hres_q;
    vres_d  = vres_q;
    if (frame_start_i) begin
      en_d    = osd_ip_en;
      x0_d    = coordinate[15:0];
      y0_d    = coordinate[31:16];
      color_d = rgb_color;
      num_d   = osd_num;
      hres_d  = h_res;
      vres_d  = v_res;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel position counters
  // --------------------------------------------------------------------------
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [15:0] w_h_cur;
  logic [15:0] w_v_cur;

  // Position of the pixel presented this cycle.
  assign w_h_cur = frame_start_i ? 16'd0 : h_cnt_q;
  assign w_v_cur = frame_start_i ? 16'd0 : v_cnt_q;

  always_comb begin
    h_cnt_d = w_h_cur;
    v_cnt_d = w_v_cur;
    if (!osd_ip_rstn) begin
      h_cnt_d = 16'd0;
      v_cnt_d = 16'd0;
    end else if (data_valid_i) begin
      if (w_h_cur == 16'(hres_d - 16'd1)) begin
        h_cnt_d = 16'd0;
        if (w_v_cur == 16'(vres_d - 16'd1)) begin
          v_cnt_d = 16'd0;
        end else begin
          v_cnt_d = w_v_cur + 16'd1;
        end
      end else begin
        h_cnt_d = w_h_cur + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Box / glyph decode for the current pixel
  // --------------------------------------------------------------------------
  logic [16:0] w_dx;
  logic [16:0] w_dy;
  logic        w_in_box;
  logic [1:0]  w_dig;
  logic [2:0]  w_col;
  logic [2:0]  w_row;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg;
  logic        w_c_mid;
  logic        w_r_top;
  logic        w_r_bot;
  logic        w_lit;
  logic        w_hit;

  // 17-bit differences: bit 16 set means the pixel lies left of / above the box.
  assign w_dx     = {1'b0, w_h_cur} - {1'b0, x0_d};
  assign w_dy     = {1'b0, w_v_cur} - {1'b0, y0_d};
  assign w_in_box = !w_dx[16] && (w_dx[15:0] < BOX_W) &&
                    !w_dy[16] && (w_dy[15:0] < BOX_H);

  assign w_dig = w_dx[3+SCALE_LOG2 +: 2];
  assign w_col = w_dx[SCALE_LOG2 +: 3];
  assign w_row = w_dy[SCALE_LOG2 +: 3];

  always_comb begin
    case (w_dig)
      2'd0:    w_nibble = num_d[11:8];
      2'd1:    w_nibble = num_d[7:4];
      default: w_nibble = num_d[3:0];
    endcase
  end

  // Segment bits: [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g
  function automatic logic [6:0] seg_map(input logic [3:0] d);
    case (d)
      4'h0:    seg_map = 7'b1111110;
      4'h1:    seg_map = 7'b0110000;
      4'h2:    seg_map = 7'b1101101;
      4'h3:    seg_map = 7'b1111001;
      4'h4:    seg_map = 7'b0110011;
      4'h5:    seg_map = 7'b1011011;
      4'h6:    seg_map = 7'b1011111;
      4'h7:    seg_map = 7'b1110000;
      4'h8:    seg_map = 7'b1111111;
      4'h9:    seg_map = 7'b1111011;
      4'hA:    seg_map = 7'b1110111;
      4'hB:    seg_map = 7'b0011111;
      4'hC:    seg_map = 7'b1001110;
      4'hD:    seg_map = 7'b0111101;
      4'hE:    seg_map = 7'b1001111;
      default: seg_map = 7'b1000111;
    endcase
  endfunction

  assign w_seg   = seg_map(w_nibble);
  assign w_c_mid = (w_col >= 3'd1) && (w_col <= 3'd4);
  assign w_r_top = (w_row == 3'd1) || (w_row == 3'd2);
  assign w_r_bot = (w_row == 3'd4) || (w_row == 3'd5);

  // Column 6-7 and row 7 never match any term below, so they stay background.
  assign w_lit = (w_seg[6] && (w_row == 3'd0) && w_c_mid) ||
                 (w_seg[5] && (w_col == 3'd5) && w_r_top) ||
                 (w_seg[4] && (w_col == 3'd5) && w_r_bot) ||
                 (w_seg[3] && (w_row == 3'd6) && w_c_mid) ||
                 (w_seg[2] && (w_col == 3'd0) && w_r_bot) ||
                 (w_seg[1] && (w_col == 3'd0) && w_r_top) ||
                 (w_seg[0] && (w_row == 3'd3) && w_c_mid);

  assign w_hit = w_in_box && w_lit && en_d &&
                 (hres_d != 16'd0) && (vres_d != 16'd0);

  // --------------------------------------------------------------------------
  // Stage 1: pixel, valid, hit and the colour in force for that pixel
  // --------------------------------------------------------------------------
  logic                    vld1_q, vld1_d;
  logic                    hit1_q, hit1_d;
  logic [23:0]             col1_q, col1_d;
  logic [G_DATA_WIDTH-1:0] r1_q, r1_d;
  logic [G_DATA_WIDTH-1:0] g1_q, g1_d;
  logic [G_DATA_WIDTH-1:0] b1_q, b1_d;

  always_comb begin
    vld1_d = osd_ip_rstn && data_valid_i;
    hit1_d = hit1_q;
    col1_d = col1_q;
    r1_d   = r1_q;
    g1_d   = g1_q;
    b1_d   = b1_q;
    if (data_valid_i) begin
      hit1_d = w_hit;
      col1_d = color_d;
      r1_d   = r_i;
      g1_d   = g_i;
      b1_d   = b_i;
    end
  end

  // Overlay colour aligned to the MSBs of each component.
  logic [G_DATA_WIDTH-1:0] w_fg_r;
  logic [G_DATA_WIDTH-1:0] w_fg_g;
  logic [G_DATA_WIDTH-1:0] w_fg_b;

  generate
    if (G_DATA_WIDTH == 8) begin : g_fg_eq
      assign w_fg_r = col1_q[23:16];
      assign w_fg_g = col1_q[15:8];
      assign w_fg_b = col1_q[7:0];
    end else if (G_DATA_WIDTH > 8) begin : g_fg_wide
      assign w_fg_r = {col1_q[23:16], {(G_DATA_WIDTH-8){1'b0}}};
      assign w_fg_g = {col1_q[15:8],  {(G_DATA_WIDTH-8){1'b0}}};
      assign w_fg_b = {col1_q[7:0],   {(G_DATA_WIDTH-8){1'b0}}};
    end else begin : g_fg_narrow
      assign w_fg_r = col1_q[23 -: G_DATA_WIDTH];
      assign w_fg_g = col1_q[15 -: G_DATA_WIDTH];
      assign w_fg_b = col1_q[7  -: G_DATA_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage 2: output mux; data only moves when a valid pixel is delivered
  // --------------------------------------------------------------------------
  logic                    vld_o_q, vld_o_d;
  logic [G_DATA_WIDTH-1:0] r_o_q, r_o_d;
  logic [G_DATA_WIDTH-1:0] g_o_q, g_o_d;
  logic [G_DATA_WIDTH-1:0] b_o_q, b_o_d;

  always_comb begin
    vld_o_d = osd_ip_rstn && vld1_q;
    r_o_d   = r_o_q;
    g_o_d   = g_o_q;
    b_o_d   = b_o_q;
    if (vld_o_d) begin
      r_o_d = hit1_q ? w_fg_r : r1_q;
      g_o_d = hit1_q ? w_fg_g : g1_q;
      b_o_d = hit1_q ? w_fg_b : b1_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q    <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      color_q <= '0;
      num_q   <= '0;
      hres_q  <= '0;
      vres_q  <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      vld1_q  <= 1'b0;
      hit1_q  <= 1'b0;
      col1_q  <= '0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      vld_o_q <= 1'b0;
      r_o_q   <= '0;
      g_o_q   <= '0;
      b_o_q   <= '0;
    end else begin
      en_q    <= en_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      color_q <= color_d;
      num_q   <= num_d;
      hres_q  <= hres_d;
      vres_q  <= vres_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      vld1_q  <= vld1_d;
      hit1_q  <= hit1_d;
      col1_q  <= col1_d;
      r1_q    <= r1_d;
      g1_q    <= g1_d;
      b1_q    <= b1_d;
      vld_o_q <= vld_o_d;
      r_o_q   <= r_o_d;
      g_o_q   <= g_o_d;
      b_o_q   <= b_o_d;
    end
  end

  assign data_valid_o = vld_o_q;
  assign r_o          = r_o_q;
  assign g_o          = g_o_q;
  assign b_o          = b_o_q;

endmodule
`default_nettype wire

// File: tb/tb_osd_num_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osd_num_overlay
//  Description : Directed self-checking bench. dut0 uses SCALE_LOG2=0,
//                dut1 uses SCALE_LOG2=1; both share the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_osd_num_overlay;

  logic        aclk;
  logic        aresetn;
  logic        osd_ip_en;
  logic        osd_ip_rstn;
  logic [31:0] coordinate;
  logic [23:0] rgb_color;
  logic [11:0] osd_num;
  logic [15:0] h_res;
  logic [15:0] v_res;
  logic        frame_start_i;
  logic        data_valid_i;
  logic [7:0]  r_i, g_i, b_i;
  logic        dv0, dv1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;

  int checks   = 0;
  int failures = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];

  osd_num_overlay #(.G_DATA_WIDTH(8), .SCALE_LOG2(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .osd_ip_en(osd_ip_en), .osd_ip_rstn(osd_ip_rstn),
    .coordinate(coordinate), .rgb_color(rgb_color), .osd_num(osd_num),
    .h_res(h_res), .v_res(v_res), .frame_start_i(frame_start_i),
    .data_valid_i(data_valid_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .data_valid_o(dv0), .r_o(r0), .g_o(g0), .b_o(b0)
  );

  osd_num_overlay #(.G_DATA_WIDTH(8), .SCALE_LOG2(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .osd_ip_en(osd_ip_en), .osd_ip_rstn(osd_ip_rstn),
    .coordinate(coordinate), .rgb_color(rgb_color), .osd_num(osd_num),
    .h_res(h_res), .v_res(v_res), .frame_start_i(frame_start_i),
    .data_valid_i(data_valid_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .data_valid_o(dv1), .r_o(r1), .g_o(g1), .b_o(b1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Capture every delivered output pixel in order, sampled mid-cycle.
  always @(negedge aclk) begin
    if (dv0 === 1'b1) q0.push_back({r0, g0, b0});
    if (dv1 === 1'b1) q1.push_back({r1, g1, b1});
  end

  task automatic step(input logic fs, input logic v, input logic [23:0] px);
    frame_start_i = fs;
    data_valid_i  = v;
    {r_i, g_i, b_i} = px;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0);
  endtask

  task automatic set_regs(input logic en, input logic [31:0] crd, input logic [23:0] col,
                          input logic [11:0] num, input logic [15:0] hr, input logic [15:0] vr);
    osd_ip_en  = en;
    coordinate = crd;
    rgb_color  = col;
    osd_num    = num;
    h_res      = hr;
    v_res      = vr;
  endtask

  // Frame start pulse followed by w*h valid pixels of a flat colour.
  task automatic flat_frame(input int w, input int h, input logic [23:0] bg);
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < w * h; i++) step(1'b0, 1'b1, bg);
    idle(4);
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    osd_ip_rstn = 1'b1;
    set_regs(1'b1, 32'h0, 24'hFFFFFF, 12'h888, 16'd64, 16'd32);
    frame_start_i = 1'b0;
    data_valid_i  = 1'b1;
    {r_i, g_i, b_i} = 24'hABCDEF;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (dv0 !== 1'b0 || {r0, g0, b0} !== 24'h0 || dv1 !== 1'b0 || {r1, g1, b1} !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: got dv0=%b rgb0=%h dv1=%b rgb1=%h, want all 0",
               dv0, {r0, g0, b0}, dv1, {r1, g1, b1});
    end
    aresetn = 1'b1;
  endtask

  // Without any frame start the shadow enable is still 0: pure passthrough.
  task automatic test_no_shadow;
    int bad;
    q0.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 24'h010101 * (i + 1));
    idle(3);
    bad = 0;
    for (int i = 0; i < 6; i++) if (q0[i] !== 24'h010101 * (i + 1)) bad++;
    checks++;
    if (q0.size() != 6 || bad != 0) begin
      failures++;
      $display("FAIL no_shadow_passthrough: got count=%0d bad=%0d, want count=6 bad=0", q0.size(), bad);
    end
  endtask

  task automatic test_async_reset;
    step(1'b0, 1'b1, 24'h5A5A5A);
    step(1'b0, 1'b0, 24'h0);
    checks++;
    if (dv0 !== 1'b1 || {r0, g0, b0} !== 24'h5A5A5A) begin
      failures++;
      $display("FAIL async_precond: got dv=%b rgb=%h, want dv=1 rgb=5a5a5a", dv0, {r0, g0, b0});
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (dv0 !== 1'b0 || {r0, g0, b0} !== 24'h0) begin
      failures++;
      $display("FAIL async_reset: got dv=%b rgb=%h, want dv=0 rgb=000000", dv0, {r0, g0, b0});
    end
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_default_draw;
    int c1, c2, tot;
    set_regs(1'b1, 32'h0010_0010, 24'hFFFFFF, 12'h123, 16'd64, 16'd32);
    q0.delete();
    flat_frame(64, 32, 24'h0);
    checks++;
    if (q0.size() != 2048) begin
      failures++;
      $display("FAIL draw_count: got %0d pixels, want 2048", q0.size());
    end
    checks++;
    if (q0[17*64+21] !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL draw_21_17: got %h, want ffffff", q0[17*64+21]);
    end
    checks++;
    if (q0[16*64+16] !== 24'h000000) begin
      failures++;
      $display("FAIL draw_16_16: got %h, want 000000", q0[16*64+16]);
    end
    checks++;
    if (q0[16*64+25] !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL draw_25_16: got %h, want ffffff", q0[16*64+25]);
    end
    c1 = 0; c2 = 0; tot = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        if (q0[y*64+x] === 24'hFFFFFF) begin
          tot++;
          if (y >= 16 && y < 24 && x >= 16 && x < 24) c1++;
          if (y >= 16 && y < 24 && x >= 24 && x < 32) c2++;
        end
    checks++;
    if (c1 != 4 || c2 != 16 || tot != 36) begin
      failures++;
      $display("FAIL draw_lit_counts: got one=%0d two=%0d total=%0d, want 4 16 36", c1, c2, tot);
    end
  endtask

  task automatic test_latency;
    set_regs(1'b1, 32'h0, 24'h00FF00, 12'h888, 16'd64, 16'd32);
    step(1'b1, 1'b0, 24'h0);
    step(1'b0, 1'b1, 24'h123456);
    idle(2);
    step(1'b0, 1'b1, 24'h654321);
    checks++;
    if (dv0 !== 1'b0) begin
      failures++;
      $display("FAIL latency_t1: got dv=%b, want 0", dv0);
    end
    step(1'b0, 1'b0, 24'h0);
    checks++;
    if (dv0 !== 1'b1 || {r0, g0, b0} !== 24'h00FF00) begin
      failures++;
      $display("FAIL latency_t2: got dv=%b rgb=%h, want dv=1 rgb=00ff00", dv0, {r0, g0, b0});
    end
    step(1'b0, 1'b0, 24'h0);
    checks++;
    if (dv0 !== 1'b0 || {r0, g0, b0} !== 24'h00FF00) begin
      failures++;
      $display("FAIL latency_hold: got dv=%b rgb=%h, want dv=0 rgb=00ff00", dv0, {r0, g0, b0});
    end
  endtask

  task automatic test_shadow;
    int white, red;
    set_regs(1'b1, 32'h0010_0010, 24'hFFFFFF, 12'h123, 16'd64, 16'd32);
    q0.delete();
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 24'h0);
    osd_num   = 12'hFFF;
    rgb_color = 24'hFF0000;
    for (int i = 512; i < 2048; i++) step(1'b0, 1'b1, 24'h0);
    idle(4);
    white = 0; red = 0;
    foreach (q0[i]) begin
      if (q0[i] === 24'hFFFFFF) white++;
      if (q0[i] === 24'hFF0000) red++;
    end
    checks++;
    if (q0[17*64+21] !== 24'hFFFFFF || q0[17*64+16] !== 24'h0 || white != 36 || red != 0) begin
      failures++;
      $display("FAIL shadow_current: got p21=%h p16=%h white=%0d red=%0d, want ffffff 000000 36 0",
               q0[17*64+21], q0[17*64+16], white, red);
    end
    q0.delete();
    flat_frame(64, 32, 24'h0);
    red = 0;
    foreach (q0[i]) if (q0[i] === 24'hFF0000) red++;
    checks++;
    if (q0[17*64+16] !== 24'hFF0000 || q0[17*64+21] !== 24'h0 || red != 36) begin
      failures++;
      $display("FAIL shadow_next: got p16=%h p21=%h red=%0d, want ff0000 000000 36",
               q0[17*64+16], q0[17*64+21], red);
    end
  endtask

  // Sends a 16x8 frame of position-coded pixels; returns pixels that differ from input.
  task automatic coded_frame(output int bad, output int cnt);
    q0.delete();
    step(1'b1, 1'b0, 24'h0);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) step(1'b0, 1'b1, {8'(x), 8'(y), 8'hA5});
    idle(4);
    bad = 0;
    cnt = q0.size();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++)
        if (q0[y*16+x] !== {8'(x), 8'(y), 8'hA5}) bad++;
  endtask

  task automatic test_disable;
    int bad, cnt;
    set_regs(1'b0, 32'h0, 24'hFFFFFF, 12'h888, 16'd16, 16'd8);
    coded_frame(bad, cnt);
    checks++;
    if (bad != 0 || cnt != 128) begin
      failures++;
      $display("FAIL disable_en0: got bad=%0d count=%0d, want 0 128", bad, cnt);
    end
    set_regs(1'b1, 32'h0, 24'hFFFFFF, 12'h888, 16'd0, 16'd8);
    coded_frame(bad, cnt);
    checks++;
    if (bad != 0 || cnt != 128) begin
      failures++;
      $display("FAIL disable_hres0: got bad=%0d count=%0d, want 0 128", bad, cnt);
    end
    set_regs(1'b1, 32'h0, 24'hFFFFFF, 12'h888, 16'd16, 16'd8);
    coded_frame(bad, cnt);
    checks++;
    if (q0[1] !== 24'hFFFFFF || q0[0] !== 24'h0000A5) begin
      failures++;
      $display("FAIL enabled_control: got p0=%h p1=%h, want 0000a5 ffffff", q0[0], q0[1]);
    end
  endtask

  task automatic test_soft_reset;
    set_regs(1'b1, 32'h0, 24'h0000FF, 12'h888, 16'd64, 16'd32);
    q0.delete();
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 5*64 + 40; i++) step(1'b0, 1'b1, 24'h111111);
    osd_ip_rstn = 1'b0;
    step(1'b0, 1'b1, 24'h222222);
    osd_ip_rstn = 1'b1;
    checks++;
    if (dv0 !== 1'b0 || {r0, g0, b0} !== 24'h111111) begin
      failures++;
      $display("FAIL srst_drop1: got dv=%b rgb=%h, want dv=0 rgb=111111", dv0, {r0, g0, b0});
    end
    step(1'b0, 1'b1, 24'h333333);
    checks++;
    if (dv0 !== 1'b0) begin
      failures++;
      $display("FAIL srst_drop2: got dv=%b, want 0", dv0);
    end
    step(1'b0, 1'b1, 24'h444444);
    checks++;
    if (dv0 !== 1'b1 || {r0, g0, b0} !== 24'h333333) begin
      failures++;
      $display("FAIL srst_origin_bg: got dv=%b rgb=%h, want dv=1 rgb=333333", dv0, {r0, g0, b0});
    end
    step(1'b0, 1'b0, 24'h0);
    checks++;
    if (dv0 !== 1'b1 || {r0, g0, b0} !== 24'h0000FF) begin
      failures++;
      $display("FAIL srst_pixel1_lit: got dv=%b rgb=%h, want dv=1 rgb=0000ff", dv0, {r0, g0, b0});
    end
    idle(3);
    checks++;
    if (q0.size() != 361) begin
      failures++;
      $display("FAIL srst_total: got %0d outputs, want 361", q0.size());
    end
  endtask

  task automatic test_clip;
    int tot, left, low;
    set_regs(1'b1, 32'h0000_003C, 24'hFF00FF, 12'h888, 16'd64, 16'd8);
    step(1'b1, 1'b0, 24'h0);
    q1.delete();
    step(1'b1, 1'b1, 24'h0);
    for (int i = 1; i < 512; i++) step(1'b0, 1'b1, 24'h0);
    idle(4);
    tot = 0; left = 0; low = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 64; x++)
        if (q1[y*64+x] === 24'hFF00FF) begin
          tot++;
          if (x < 60) left++;
          if (x < 4) low++;
        end
    checks++;
    if (q1.size() != 512 || tot != 16 || left != 0 || low != 0) begin
      failures++;
      $display("FAIL clip_counts: got count=%0d lit=%0d left=%0d cols0_3=%0d, want 512 16 0 0",
               q1.size(), tot, left, low);
    end
    checks++;
    if (q1[62] !== 24'hFF00FF || q1[60] !== 24'h0 || q1[2*64+60] !== 24'hFF00FF ||
        q1[2*64+62] !== 24'h0 || q1[6*64+63] !== 24'hFF00FF) begin
      failures++;
      $display("FAIL clip_pixels: got p62_0=%h p60_0=%h p60_2=%h p62_2=%h p63_6=%h, want ff00ff 000000 ff00ff 000000 ff00ff",
               q1[62], q1[60], q1[2*64+60], q1[2*64+62], q1[6*64+63]);
    end
  endtask

  initial begin
    test_reset();
    test_no_shadow();
    test_async_reset();
    test_default_draw();
    test_latency();
    test_shadow();
    test_disable();
    test_soft_reset();
    test_clip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
